// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the data-memory bridge.
// Holds FSM state encoding, transfer size codes and kseg segment tags.
package mem_bridge_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [2:0] KSEG0 = 3'b100;
    localparam logic [2:0] KSEG1 = 3'b101;

endpackage

// File: rtl/mem_addr_map.sv
// Virtual-to-physical address fold plus size/offset decode from wen.
// Ports: vaddr_i, wen_i -> paddr_o (physical, low bits = lane), size_o.
module mem_addr_map
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAP_KSEG = 1
) (
    input  logic [ADDR_W-1:0] vaddr_i,
    input  logic [3:0]        wen_i,
    output logic [ADDR_W-1:0] paddr_o,
    output logic [1:0]        size_o
);

    logic [1:0]        off;
    logic [2:0]        seg;
    logic [ADDR_W-1:0] mapped;

    always_comb begin
        size_o = SIZE_WORD;
        off    = 2'b00;
        // Loads and irregular masks fall through as aligned words.
        case (wen_i)
            4'b0011: begin size_o = SIZE_HALF; off = 2'b00; end
            4'b1100: begin size_o = SIZE_HALF; off = 2'b10; end
            4'b0001: begin size_o = SIZE_BYTE; off = 2'b00; end
            4'b0010: begin size_o = SIZE_BYTE; off = 2'b01; end
            4'b0100: begin size_o = SIZE_BYTE; off = 2'b10; end
            4'b1000: begin size_o = SIZE_BYTE; off = 2'b11; end
            default: ;
        endcase
    end

    always_comb begin
        seg    = vaddr_i[ADDR_W-1 -: 3];
        mapped = vaddr_i;
        if ((MAP_KSEG != 0) && (seg == KSEG0 || seg == KSEG1))
            mapped[ADDR_W-1 -: 3] = 3'b000;
        mapped[1:0] = off;
        paddr_o     = mapped;
    end

endmodule

// File: rtl/d_mem_bridge.sv
// Turns the MEM-stage data access into one sram-like req/addr_ok/data_ok
// transaction. Ports: M-stage request in, readdata out, d_stall out, bus side.
module d_mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAP_KSEG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_enM,
    input  logic [3:0]        mem_wenM,
    input  logic [ADDR_W-1:0] mem_addrM,
    input  logic [DATA_W-1:0] mem_wdataM,
    output logic [DATA_W-1:0] mem_rdataM,
    input  logic              longest_stall,
    output logic              d_stall,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    state_t            state_q;
    logic [DATA_W-1:0] rdata_q;
    logic              is_idle, is_addr, is_data;

    mem_addr_map #(
        .ADDR_W  (ADDR_W),
        .MAP_KSEG(MAP_KSEG)
    ) u_map (
        .vaddr_i(mem_addrM),
        .wen_i  (mem_wenM),
        .paddr_o(data_addr),
        .size_o (data_size)
    );

    assign is_idle = (state_q == S_IDLE);
    assign is_addr = (state_q == S_ADDR);
    assign is_data = (state_q == S_DATA);

    // Gated by rst so nothing leaks onto the bus during reset.
    assign data_req   = rst & ((is_idle & mem_enM) | is_addr);
    assign d_stall    = rst & ((is_idle & mem_enM) | is_addr | is_data);
    assign data_wr    = |mem_wenM;
    assign data_wdata = mem_wdataM;
    assign mem_rdataM = rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rdata_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (mem_enM)
                        state_q <= data_addr_ok ? S_DATA : S_ADDR;
                end
                S_ADDR: begin
                    if (data_addr_ok)
                        state_q <= S_DATA;
                end
                S_DATA: begin
                    if (data_data_ok) begin
                        state_q <= S_HOLD;
                        rdata_q <= data_rdata;
                    end
                end
                // Holding here until the freeze lifts stops a frozen
                // instruction from issuing a second transaction.
                S_HOLD: begin
                    if (!longest_stall)
                        state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_d_mem_bridge.sv
// Directed self-checking bench for d_mem_bridge.
// Inputs change 1ns after the rising edge, outputs checked 1ns later.
module tb_d_mem_bridge;

    logic        clk;
    logic        rst;
    logic        mem_enM;
    logic [3:0]  mem_wenM;
    logic [31:0] mem_addrM;
    logic [31:0] mem_wdataM;
    logic [31:0] mem_rdataM;
    logic        longest_stall;
    logic        d_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    int n_cmp;
    int n_err;

    d_mem_bridge #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .MAP_KSEG(1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_enM      (mem_enM),
        .mem_wenM     (mem_wenM),
        .mem_addrM    (mem_addrM),
        .mem_wdataM   (mem_wdataM),
        .mem_rdataM   (mem_rdataM),
        .longest_stall(longest_stall),
        .d_stall      (d_stall),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        mem_enM = 1'b1;
        mem_wenM = 4'b0000;
        mem_addrM = 32'h8000_1004;
        mem_wdataM = '0;
        longest_stall = 1'b0;
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        data_rdata = '0;

        // Reset: bus and stall gated even with mem_enM high
        step();
        step();
        #1;
        chk("rst_stall", 32'(d_stall), 32'd0);
        chk("rst_req", 32'(data_req), 32'd0);
        chk("rst_rdata", mem_rdataM, 32'h0);

        // Load word, best case
        step();
        rst = 1'b1;
        data_addr_ok = 1'b1;
        #1;
        chk("lw_req", 32'(data_req), 32'd1);
        chk("lw_stall0", 32'(d_stall), 32'd1);
        chk("lw_addr", data_addr, 32'h0000_1004);
        chk("lw_size", 32'(data_size), 32'd2);
        chk("lw_wr", 32'(data_wr), 32'd0);
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata = 32'hDEAD_BEEF;
        #1;
        chk("lw_req_once", 32'(data_req), 32'd0);
        chk("lw_stall1", 32'(d_stall), 32'd1);
        step();
        data_data_ok = 1'b0;
        #1;
        chk("lw_hold_stall", 32'(d_stall), 32'd0);
        chk("lw_hold_req", 32'(data_req), 32'd0);
        chk("lw_rdata", mem_rdataM, 32'hDEAD_BEEF);

        // Store byte wen=0100, kseg1
        step();
        mem_wenM = 4'b0100;
        mem_addrM = 32'hA000_2003;
        mem_wdataM = 32'h00AB_0000;
        data_addr_ok = 1'b1;
        #1;
        chk("sb_req", 32'(data_req), 32'd1);
        chk("sb_addr", data_addr, 32'h0000_2002);
        chk("sb_size", 32'(data_size), 32'd0);
        chk("sb_wr", 32'(data_wr), 32'd1);
        chk("sb_wdata", data_wdata, 32'h00AB_0000);
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata = 32'h1111_1111;
        #1;
        chk("sb_stall", 32'(d_stall), 32'd1);
        step();
        data_data_ok = 1'b0;
        #1;
        chk("sb_stall_clr", 32'(d_stall), 32'd0);
        chk("sb_rdata", mem_rdataM, 32'h1111_1111);

        // addr_ok withheld 3 cycles; stray data_ok in ADDR ignored
        step();
        mem_wenM = 4'b0000;
        mem_addrM = 32'h0000_0040;
        data_rdata = 32'hBAD0_BAD0;
        #1;
        chk("wt_req_i", 32'(data_req), 32'd1);
        chk("wt_stall_i", 32'(d_stall), 32'd1);
        for (int i = 0; i < 2; i++) begin
            step();
            data_data_ok = 1'b1;
            #1;
            chk("wt_req_a", 32'(data_req), 32'd1);
            chk("wt_stall_a", 32'(d_stall), 32'd1);
        end
        step();
        data_data_ok = 1'b0;
        data_addr_ok = 1'b1;
        #1;
        chk("wt_req_ok", 32'(data_req), 32'd1);
        chk("wt_rdata_keep", mem_rdataM, 32'h1111_1111);
        step();
        data_addr_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("wt_req_d", 32'(data_req), 32'd0);
            chk("wt_stall_d", 32'(d_stall), 32'd1);
            step();
        end
        data_data_ok = 1'b1;
        data_rdata = 32'hCAFE_F00D;
        #1;
        chk("wt_stall_d4", 32'(d_stall), 32'd1);
        step();
        data_data_ok = 1'b0;
        #1;
        chk("wt_hold_stall", 32'(d_stall), 32'd0);
        chk("wt_rdata", mem_rdataM, 32'hCAFE_F00D);

        // Global freeze during HOLD: no re-issue
        step();
        mem_addrM = 32'h0000_0080;
        data_addr_ok = 1'b1;
        longest_stall = 1'b1;
        #1;
        chk("fz_req", 32'(data_req), 32'd1);
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata = 32'h5A5A_5A5A;
        step();
        data_data_ok = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("fz_stall", 32'(d_stall), 32'd0);
            chk("fz_req_h", 32'(data_req), 32'd0);
            chk("fz_rdata", mem_rdataM, 32'h5A5A_5A5A);
            step();
        end
        longest_stall = 1'b0;
        #1;
        chk("fz_last_req", 32'(data_req), 32'd0);
        step();
        mem_addrM = 32'h9000_0100;
        #1;
        chk("fz_idle_req", 32'(data_req), 32'd1);
        chk("fz_k0_addr", data_addr, 32'h1000_0100);
        step();
        data_addr_ok = 1'b1;
        #1;
        chk("rs_addr_req", 32'(data_req), 32'd1);
        step();
        data_addr_ok = 1'b0;
        #1;
        chk("rs_data_stall", 32'(d_stall), 32'd1);

        // Reset in DATA; stray and late data_ok dropped
        rst = 1'b0;
        #1;
        chk("rs_stall", 32'(d_stall), 32'd0);
        chk("rs_req", 32'(data_req), 32'd0);
        chk("rs_rdata", mem_rdataM, 32'h0);
        data_data_ok = 1'b1;
        data_rdata = 32'h1234_5678;
        step();
        chk("rs_rdata_ok", mem_rdataM, 32'h0);
        step();
        rst = 1'b1;
        mem_enM = 1'b0;
        #1;
        chk("rs_rel_stall", 32'(d_stall), 32'd0);
        chk("rs_rel_req", 32'(data_req), 32'd0);
        step();
        data_data_ok = 1'b0;
        #1;
        chk("rs_late", mem_rdataM, 32'h0);

        // Back-to-back half stores
        step();
        mem_enM = 1'b1;
        mem_wenM = 4'b1100;
        mem_addrM = 32'hC000_3001;
        mem_wdataM = 32'h1234_0000;
        data_addr_ok = 1'b1;
        #1;
        chk("sh1_req", 32'(data_req), 32'd1);
        chk("sh1_addr", data_addr, 32'hC000_3002);
        chk("sh1_size", 32'(data_size), 32'd1);
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        #1;
        chk("sh1_once", 32'(data_req), 32'd0);
        step();
        data_data_ok = 1'b0;
        #1;
        chk("sh1_hold", 32'(data_req), 32'd0);
        step();
        mem_wenM = 4'b0011;
        mem_addrM = 32'h0000_3006;
        mem_wdataM = 32'h0000_5678;
        data_addr_ok = 1'b1;
        #1;
        chk("sh2_req", 32'(data_req), 32'd1);
        chk("sh2_addr", data_addr, 32'h0000_3004);
        chk("sh2_size", 32'(data_size), 32'd1);
        step();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        #1;
        chk("sh2_once", 32'(data_req), 32'd0);
        step();
        data_data_ok = 1'b0;
        mem_enM = 1'b0;
        mem_wenM = 4'b0110;
        mem_addrM = 32'h0000_4003;
        #1;
        chk("irr_size", 32'(data_size), 32'd2);
        chk("irr_addr", data_addr, 32'h0000_4000);
        chk("irr_req", 32'(data_req), 32'd0);
        mem_wenM = 4'b0000;
        mem_addrM = 32'hBFC0_0000;
        #1;
        chk("k1_addr", data_addr, 32'h1FC0_0000);
        step();
        #1;
        chk("end_stall", 32'(d_stall), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
